// File: rtl/change_dispenser_if.sv
// Purpose: bundles the change-dispenser handshakes (change amount in, hopper
//          req/ack out, status/result out) into one interface.
// Ports (signals):
//   change_valid/change_amt/change_ready : amount handshake from vending machine
//   hopper_empty                         : per-hopper empty flags [4]=20 .. [0]=1
//   coin_req/coin_denom/coin_ack         : one-coin request handshake to hopper driver
//   busy/done/coin_count/short_amt       : transaction status and result
// Modports: master = vending machine / hopper side, slave = dispenser.
interface change_dispenser_if #(
    parameter int unsigned AMT_W = 8
);
    logic             change_valid;
    logic [AMT_W-1:0] change_amt;
    logic             change_ready;
    logic [4:0]       hopper_empty;
    logic             coin_req;
    logic [2:0]       coin_denom;
    logic             coin_ack;
    logic             busy;
    logic             done;
    logic [7:0]       coin_count;
    logic [AMT_W-1:0] short_amt;

    modport master (
        output change_valid, change_amt, hopper_empty, coin_ack,
        input  change_ready, coin_req, coin_denom, busy, done, coin_count, short_amt
    );

    modport slave (
        input  change_valid, change_amt, hopper_empty, coin_ack,
        output change_ready, coin_req, coin_denom, busy, done, coin_count, short_amt
    );
endinterface

// File: rtl/change_dispenser.sv
// Purpose: pays out a change amount as coins, greedily taking the largest
//          available denomination (20,10,5,2,1), skipping empty or jammed
//          hoppers, and reporting coins paid plus any shortfall.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-low reset
//   bus : change_dispenser_if.slave (amount handshake, hopper req/ack, results)
module change_dispenser #(
    parameter int unsigned AMT_W       = 8,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    change_dispenser_if.slave   bus
);
    localparam int unsigned NUM_HOP = 5;
    localparam int unsigned DEN_W   = 3;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned TMR_W   = $clog2(ACK_TIMEOUT);

    typedef enum logic [1:0] {IDLE, SELECT, REQ, DONE} state_t;

    state_t             state_q, state_n;
    logic [AMT_W-1:0]   remaining_q, remaining_n;
    logic [NUM_HOP-1:0] jam_q, jam_n;
    logic [TMR_W-1:0]   timer_q, timer_n;
    logic               coin_req_q, coin_req_n;
    logic [DEN_W-1:0]   coin_denom_q, coin_denom_n;
    logic               done_q, done_n;
    logic [CNT_W-1:0]   coin_count_q, coin_count_n;
    logic [AMT_W-1:0]   short_amt_q, short_amt_n;

    logic               found;
    logic [DEN_W-1:0]   sel_idx;
    logic [DEN_W-1:0]   hop_idx;

    // Face value of hopper index 0..4.
    function automatic logic [AMT_W-1:0] coin_value(input logic [DEN_W-1:0] idx);
        case (idx)
            3'd0:    coin_value = AMT_W'(1);
            3'd1:    coin_value = AMT_W'(2);
            3'd2:    coin_value = AMT_W'(5);
            3'd3:    coin_value = AMT_W'(10);
            3'd4:    coin_value = AMT_W'(20);
            default: coin_value = '0;
        endcase
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            jam_q        <= '0;
            timer_q      <= '0;
            coin_req_q   <= 1'b0;
            coin_denom_q <= '0;
            done_q       <= 1'b0;
            coin_count_q <= '0;
            short_amt_q  <= '0;
        end else begin
            state_q      <= state_n;
            remaining_q  <= remaining_n;
            jam_q        <= jam_n;
            timer_q      <= timer_n;
            coin_req_q   <= coin_req_n;
            coin_denom_q <= coin_denom_n;
            done_q       <= done_n;
            coin_count_q <= coin_count_n;
            short_amt_q  <= short_amt_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n      = state_q;
        remaining_n  = remaining_q;
        jam_n        = jam_q;
        timer_n      = timer_q;
        coin_req_n   = coin_req_q;
        coin_denom_n = coin_denom_q;
        done_n       = 1'b0;
        coin_count_n = coin_count_q;
        short_amt_n  = short_amt_q;
        found        = 1'b0;
        sel_idx      = '0;
        hop_idx      = coin_denom_q - 3'd1;

        // Ascending scan: the last usable hopper found is the largest value.
        for (int i = 0; i < NUM_HOP; i++) begin
            if (coin_value(3'(i)) <= remaining_q && !bus.hopper_empty[i] && !jam_q[i]) begin
                found   = 1'b1;
                sel_idx = 3'(i);
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.change_valid) begin
                    remaining_n  = bus.change_amt;
                    jam_n        = '0;
                    coin_count_n = '0;
                    short_amt_n  = '0;
                    state_n      = SELECT;
                end
            end
            SELECT: begin
                if (remaining_q == '0) begin
                    coin_denom_n = '0;
                    done_n       = 1'b1;
                    state_n      = DONE;
                end else if (found) begin
                    coin_denom_n = sel_idx + 3'd1;
                    coin_req_n   = 1'b1;
                    timer_n      = '0;
                    state_n      = REQ;
                end else begin
                    short_amt_n  = remaining_q;
                    coin_denom_n = '0;
                    done_n       = 1'b1;
                    state_n      = DONE;
                end
            end
            REQ: begin
                // Ack takes priority over a timeout on the same edge.
                if (bus.coin_ack) begin
                    remaining_n  = remaining_q - coin_value(hop_idx);
                    if (coin_count_q != '1) begin
                        coin_count_n = coin_count_q + 8'd1;
                    end
                    coin_req_n   = 1'b0;
                    coin_denom_n = '0;
                    state_n      = SELECT;
                end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
                    jam_n[hop_idx] = 1'b1;
                    coin_req_n     = 1'b0;
                    coin_denom_n   = '0;
                    state_n        = SELECT;
                end else begin
                    timer_n = timer_q + TMR_W'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.change_ready = (state_q == IDLE);
    assign bus.busy         = (state_q != IDLE);
    assign bus.coin_req     = coin_req_q;
    assign bus.coin_denom   = coin_denom_q;
    assign bus.done         = done_q;
    assign bus.coin_count   = coin_count_q;
    assign bus.short_amt    = short_amt_q;
endmodule

// File: tb/tb_change_dispenser.sv
// Purpose: self-checking bench for change_dispenser. A table of transactions
//          (amount, hopper state, hopper ack behaviour, expected results) is
//          replayed in a loop, followed by hand-written reset and busy sequences.
// Ports: none (top-level bench).
module tb_change_dispenser;
    logic clk;
    logic rst;
    int   tests;
    int   failed;

    change_dispenser_if #(.AMT_W(8)) bus ();

    change_dispenser #(.AMT_W(8), .ACK_TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode 0: ack every request whose hopper is not in noack
    // mode 1: coin_ack held high for the whole transaction
    // mode 2: ack only on the ack_at-th cycle coin_req is seen high
    typedef struct {
        int         amt;
        logic [4:0] empty;
        logic [4:0] noack;
        int         mode;
        int         ack_at;
        int         exp_count;
        int         exp_short;
        int         exp_seq;
        int         exp_lat;
        int         exp_req;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    // First five paid denominations packed 3 bits each, first coin lowest.
    function automatic int seq5(input int a, input int b, input int c, input int d, input int e);
        return a | (b << 3) | (c << 6) | (d << 9) | (e << 12);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_txn(input int k, input vec_t v);
        int         lat;
        int         req_cyc;
        int         n;
        int         idx;
        bit         got_done;
        logic       ack;
        logic [14:0] seq;

        lat = 0; req_cyc = 0; n = 0; got_done = 1'b0; seq = '0;
        bus.hopper_empty = v.empty;
        bus.change_amt   = 8'(v.amt);
        bus.change_valid = 1'b1;
        bus.coin_ack     = (v.mode == 1);
        for (int c = 0; c < 600 && !got_done; c++) begin
            step();
            lat++;
            bus.change_valid = 1'b0;
            if (bus.coin_req) req_cyc++;
            idx = int'(bus.coin_denom) - 1;
            case (v.mode)
                0:       ack = bus.coin_req && idx >= 0 && idx < 5 && !v.noack[idx];
                1:       ack = 1'b1;
                default: ack = bus.coin_req && (req_cyc == v.ack_at);
            endcase
            bus.coin_ack = ack;
            if (bus.coin_req && ack) begin
                if (n < 5) seq[3*n +: 3] = bus.coin_denom;
                n++;
            end
            if (bus.done) got_done = 1'b1;
        end
        bus.coin_ack = 1'b0;
        check($sformatf("v%0d_done_seen", k), int'(got_done), 1);
        check($sformatf("v%0d_count", k), int'(bus.coin_count), v.exp_count);
        check($sformatf("v%0d_short", k), int'(bus.short_amt), v.exp_short);
        check($sformatf("v%0d_seq", k), int'(seq), v.exp_seq);
        check($sformatf("v%0d_latency", k), lat, v.exp_lat);
        check($sformatf("v%0d_req_cycles", k), req_cyc, v.exp_req);
        step();
        check($sformatf("v%0d_done_one_cycle", k), int'(bus.done), 0);
        check($sformatf("v%0d_ready_after", k), int'(bus.change_ready), 1);
    endtask

    initial begin
        int  n_done;
        bit  saw_done;

        tests = 0;
        failed = 0;

        //            amt empty     noack     md at  cnt sh  seq                    lat req
        vecs[0]  = '{15,  5'b00000, 5'b00000, 0, 0,  2,  0, seq5(4,3,0,0,0),        6,  2};
        vecs[1]  = '{38,  5'b00000, 5'b00000, 0, 0,  5,  0, seq5(5,4,3,2,1),        12, 5};
        vecs[2]  = '{0,   5'b00000, 5'b00000, 0, 0,  0,  0, 0,                      2,  0};
        vecs[3]  = '{10,  5'b01000, 5'b00000, 0, 0,  2,  0, seq5(3,3,0,0,0),        6,  2};
        vecs[4]  = '{20,  5'b00000, 5'b10000, 0, 0,  2,  0, seq5(4,4,0,0,0),        23, 18};
        vecs[5]  = '{20,  5'b00000, 5'b00000, 0, 0,  1,  0, seq5(5,0,0,0,0),        4,  1};
        vecs[6]  = '{7,   5'b11111, 5'b00000, 0, 0,  0,  7, 0,                      2,  0};
        vecs[7]  = '{8,   5'b00011, 5'b00000, 0, 0,  1,  3, seq5(3,0,0,0,0),        4,  1};
        vecs[8]  = '{6,   5'b00000, 5'b00001, 0, 0,  1,  1, seq5(3,0,0,0,0),        21, 17};
        vecs[9]  = '{3,   5'b00000, 5'b00000, 1, 0,  2,  0, seq5(2,1,0,0,0),        6,  2};
        vecs[10] = '{1,   5'b00000, 5'b00000, 2, 16, 1,  0, seq5(1,0,0,0,0),        19, 16};
        vecs[11] = '{255, 5'b11110, 5'b00000, 0, 0,  255, 0, seq5(1,1,1,1,1),       512, 255};

        rst = 1'b0;
        bus.change_valid = 1'b0;
        bus.change_amt   = '0;
        bus.hopper_empty = '0;
        bus.coin_ack     = 1'b0;
        step();
        step();
        check("rst_ready", int'(bus.change_ready), 1);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_coin_req", int'(bus.coin_req), 0);
        check("rst_coin_denom", int'(bus.coin_denom), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_count", int'(bus.coin_count), 0);
        check("rst_short", int'(bus.short_amt), 0);
        rst = 1'b1;
        step();

        for (int k = 0; k < NVEC; k++) begin
            run_txn(k, vecs[k]);
        end

        // New amount presented while busy must be ignored.
        bus.hopper_empty = '0;
        bus.change_amt   = 8'd5;
        bus.change_valid = 1'b1;
        step();
        bus.change_amt = 8'd9;
        saw_done = 1'b0;
        for (int c = 0; c < 40 && !saw_done; c++) begin
            step();
            bus.coin_ack = bus.coin_req;
            if (bus.done) begin
                saw_done = 1'b1;
                bus.change_valid = 1'b0;
            end
        end
        bus.change_valid = 1'b0;
        check("busy_ign_done", int'(saw_done), 1);
        check("busy_ign_count", int'(bus.coin_count), 1);
        check("busy_ign_short", int'(bus.short_amt), 0);
        step();
        check("busy_ign_idle", int'(bus.change_ready), 1);
        step();
        check("busy_ign_no_restart", int'(bus.busy), 0);

        // Reset in the middle of a coin request.
        bus.coin_ack     = 1'b0;
        bus.change_amt   = 8'd7;
        bus.change_valid = 1'b1;
        step();
        bus.change_valid = 1'b0;
        step();
        check("midrst_req_before", int'(bus.coin_req), 1);
        check("midrst_denom_before", int'(bus.coin_denom), 3);
        step();
        step();
        rst = 1'b0;
        step();
        check("midrst_req_low", int'(bus.coin_req), 0);
        check("midrst_no_done", int'(bus.done), 0);
        check("midrst_busy", int'(bus.busy), 0);
        rst = 1'b1;
        n_done = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (bus.done) n_done++;
        end
        check("midrst_done_count", n_done, 0);
        check("midrst_ready", int'(bus.change_ready), 1);
        check("midrst_count", int'(bus.coin_count), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
